// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_sync
//  Description : Oversampled SPI slave. sclk/mosi/ce0 are synchronised into
//                the clk domain; supports configurable word width, CPOL/CPHA,
//                bit order, multi-word frames and valid/ready on RX and TX.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_sync #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ce0,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             busy,
    output logic             frame_err
);

    localparam int                 c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic               c_sclk_idle = (CPOL != 0);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_active = 1'b1;

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ce0_sync;
    logic                   r_sclk_hist;
    logic                   r_ce0_hist;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic [WIDTH-1:0]       r_rx_shift;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_overrun;
    logic                   r_word_done;
    logic [WIDTH-1:0]       r_tx_shift;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic                   r_miso_q;
    logic                   r_sampled;
    logic                   r_unr_pending;
    logic                   r_tx_underrun;
    logic                   r_frame_err;

    logic             w_sclk_s, w_mosi_s, w_ce0_s;
    logic             w_rise, w_fall, w_lead, w_trail;
    logic             w_ce0_fall, w_ce0_rise;
    logic             w_enter, w_exit, w_live;
    logic             w_sample, w_shift, w_load, w_capture;
    logic             w_tx_head, w_miso_bit;
    logic [WIDTH-1:0] w_rx_next, w_tx_shifted;

    // Reset asserts immediately and is released on a clk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Synchronisers on the asynchronous pins plus history flops for edge detect
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{c_sclk_idle}};
            r_mosi_sync <= '0;
            r_ce0_sync  <= {SYNC_STAGES{1'b1}};
            r_sclk_hist <= c_sclk_idle;
            r_ce0_hist  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ce0_sync  <= {r_ce0_sync[SYNC_STAGES-2:0], ce0};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_ce0_hist  <= r_ce0_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_ce0_s    = r_ce0_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk_s & ~r_sclk_hist;
    assign w_fall     = ~w_sclk_s & r_sclk_hist;
    assign w_lead     = (CPOL != 0) ? w_fall : w_rise;
    assign w_trail    = (CPOL != 0) ? w_rise : w_fall;
    assign w_ce0_fall = ~w_ce0_s & r_ce0_hist;
    assign w_ce0_rise = w_ce0_s & ~r_ce0_hist;

    assign w_enter = (r_state == c_st_idle) && w_ce0_fall;
    assign w_exit  = (r_state == c_st_active) && w_ce0_rise;
    assign w_live  = (r_state == c_st_active) && !w_ce0_rise;

    // CPHA=0 only shifts after a sample so the trailing edge of a word's last
    // bit cannot consume the first bit of the freshly reloaded word.
    assign w_sample  = w_live && ((CPHA != 0) ? w_trail : w_lead);
    assign w_shift   = w_live && ((CPHA != 0) ? w_lead : (w_trail && r_sampled));
    assign w_load    = w_enter || (r_word_done && w_live);
    assign w_capture = tx_valid && !r_hold_full;

    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_rx_next    = {r_rx_shift[WIDTH-2:0], w_mosi_s};
        assign w_tx_head    = r_tx_shift[WIDTH-1];
        assign w_tx_shifted = {r_tx_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_rx_next    = {w_mosi_s, r_rx_shift[WIDTH-1:1]};
        assign w_tx_head    = r_tx_shift[0];
        assign w_tx_shifted = {1'b0, r_tx_shift[WIDTH-1:1]};
    end

    if (CPHA != 0) begin : g_cpha1
        assign w_miso_bit = r_miso_q;
    end else begin : g_cpha0
        assign w_miso_bit = w_tx_head;
    end

    // FSM state register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= c_st_idle;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: frame follows synchronised ce0
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_ce0_fall) w_state_nxt = c_st_active;
            c_st_active: if (w_ce0_rise) w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs: drive miso only while selected
    always_comb begin
        busy    = 1'b0;
        miso_oe = 1'b0;
        miso    = 1'b0;
        if (r_state == c_st_active) begin
            busy    = 1'b1;
            miso_oe = 1'b1;
            miso    = w_miso_bit;
        end
    end

    // Receive shifter and bit counter, advanced on sample edges
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_exit) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
            end else if (w_enter) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_cnt_last) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_cnt_one;
                end
            end
        end
    end

    // RX output register with valid/ready and overrun detection
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (r_word_done) begin
                r_rx_data    <= r_rx_shift;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= r_rx_valid && !rx_ready;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // One-entry TX holding register; a load empties it unless refilled
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_capture) r_hold <= tx_data;
            if (w_load)         r_hold_full <= w_capture;
            else if (w_capture) r_hold_full <= 1'b1;
        end
    end

    // TX shifter. An empty reload at a word boundary only counts as an
    // underrun once the next word actually starts (its first sample edge);
    // a frame that ends on the boundary leaves no underrun behind.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_shift    <= '0;
            r_miso_q      <= 1'b0;
            r_sampled     <= 1'b0;
            r_unr_pending <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_exit) begin
                r_tx_shift    <= '0;
                r_miso_q      <= 1'b0;
                r_sampled     <= 1'b0;
                r_unr_pending <= 1'b0;
            end else if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold : '0;
                r_sampled  <= 1'b0;
                if (w_enter) begin
                    r_miso_q      <= 1'b0;
                    r_tx_underrun <= !r_hold_full;
                end else begin
                    r_unr_pending <= !r_hold_full;
                end
            end else begin
                if (w_shift) begin
                    r_tx_shift <= w_tx_shifted;
                    r_miso_q   <= w_tx_head;
                end
                if (w_sample) begin
                    r_sampled <= 1'b1;
                    if (r_unr_pending) begin
                        r_tx_underrun <= 1'b1;
                        r_unr_pending <= 1'b0;
                    end
                end
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_ready    = !r_hold_full;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_sync
//  Description : Directed self-checking bench for spi_slave_sync. Three
//                instances: [0] mode 0 / 8 bit, [1] mode 3 / 16 bit,
//                [2] mode 0 / 8 bit LSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_sync;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sclk [3]     = '{1'b0, 1'b1, 1'b0};
    logic mosi [3]     = '{1'b0, 1'b0, 1'b0};
    logic ce0 [3]      = '{1'b1, 1'b1, 1'b1};
    logic rx_ready [3] = '{1'b0, 1'b1, 1'b1};
    logic tx_valid [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0]  txd0 = '0;
    logic [15:0] txd1 = '0;
    logic [7:0]  txd2 = '0;

    logic miso_w [3];
    logic oe_w [3];
    logic rxv_w [3];
    logic ovr_w [3];
    logic txr_w [3];
    logic unr_w [3];
    logic busy_w [3];
    logic ferr_w [3];
    logic [7:0]  rxd0;
    logic [15:0] rxd1;
    logic [7:0]  rxd2;

    spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .mosi(mosi[0]), .ce0(ce0[0]),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .rx_data(rxd0), .rx_valid(rxv_w[0]),
        .rx_ready(rx_ready[0]), .rx_overrun(ovr_w[0]), .tx_data(txd0),
        .tx_valid(tx_valid[0]), .tx_ready(txr_w[0]), .tx_underrun(unr_w[0]),
        .busy(busy_w[0]), .frame_err(ferr_w[0]));

    spi_slave_sync #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .mosi(mosi[1]), .ce0(ce0[1]),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .rx_data(rxd1), .rx_valid(rxv_w[1]),
        .rx_ready(rx_ready[1]), .rx_overrun(ovr_w[1]), .tx_data(txd1),
        .tx_valid(tx_valid[1]), .tx_ready(txr_w[1]), .tx_underrun(unr_w[1]),
        .busy(busy_w[1]), .frame_err(ferr_w[1]));

    spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[2]), .mosi(mosi[2]), .ce0(ce0[2]),
        .miso(miso_w[2]), .miso_oe(oe_w[2]), .rx_data(rxd2), .rx_valid(rxv_w[2]),
        .rx_ready(rx_ready[2]), .rx_overrun(ovr_w[2]), .tx_data(txd2),
        .tx_valid(tx_valid[2]), .tx_ready(txr_w[2]), .tx_underrun(unr_w[2]),
        .busy(busy_w[2]), .frame_err(ferr_w[2]));

    int n_total = 0;
    int n_bad   = 0;

    // pulse / event counters, sampled on the falling clk edge
    int n_ovr [3];
    int n_unr [3];
    int n_ferr [3];
    int n_rxv [3];
    bit prev_v [3];
    logic [15:0] log1 [$];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ovr_w[k])  n_ovr[k]++;
            if (unr_w[k])  n_unr[k]++;
            if (ferr_w[k]) n_ferr[k]++;
            if (rxv_w[k] && !prev_v[k]) begin
                n_rxv[k]++;
                if (k == 1) log1.push_back(rxd1);
            end
            prev_v[k] = rxv_w[k];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI master: nbits bits of w, returns the bits seen on miso
    task automatic xfer(input int k, input int nbits, input int cpol, input int cpha,
                        input int msb, input logic [15:0] w, output logic [15:0] r);
        int b;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (msb != 0) ? (nbits - 1 - i) : i;
            if (cpha == 0) begin
                mosi[k] = w[b];
                tick(6);
                sclk[k] = (cpol == 0);
                r[b] = miso_w[k];
                tick(6);
                sclk[k] = (cpol != 0);
            end else begin
                sclk[k] = (cpol == 0);
                mosi[k] = w[b];
                tick(6);
                sclk[k] = (cpol != 0);
                r[b] = miso_w[k];
                tick(6);
            end
        end
    endtask

    task automatic frame_start(input int k);
        ce0[k] = 1'b0;
        tick(10);
    endtask

    task automatic frame_end(input int k);
        tick(8);
        ce0[k] = 1'b1;
        tick(10);
    endtask

    logic [15:0] rd;
    int u0, o0, f0, v0;

    initial begin
        tick(5);
        rst_n = 1'b1;
        tick(6);

        // reset state
        check_val("rst_outs0", {miso_w[0], oe_w[0], rxv_w[0], txr_w[0], busy_w[0],
                                ovr_w[0], unr_w[0], ferr_w[0]}, 8'b0001_0000);
        check_val("rst_rxd0", rxd0, 8'h00);

        // mode 0: preload 0x0F, master sends 0xA5
        u0 = n_unr[0]; f0 = n_ferr[0];
        txd0 = 8'h0F; tx_valid[0] = 1'b1;
        tick(1);
        tx_valid[0] = 1'b0;
        check_val("m0_txready_full", txr_w[0], 1'b0);
        frame_start(0);
        check_val("m0_busy_oe", {busy_w[0], oe_w[0]}, 2'b11);
        check_val("m0_txready_after_load", txr_w[0], 1'b1);
        xfer(0, 8, 0, 0, 1, 16'h00A5, rd);
        check_val("m0_miso_word", rd, 16'h000F);
        tick(10);
        check_val("m0_rx_valid", rxv_w[0], 1'b1);
        check_val("m0_rx_data", rxd0, 8'hA5);
        tick(10);
        check_val("m0_rx_valid_held", rxv_w[0], 1'b1);
        rx_ready[0] = 1'b1;
        tick(1);
        rx_ready[0] = 1'b0;
        tick(1);
        check_val("m0_rx_valid_clr", rxv_w[0], 1'b0);
        frame_end(0);
        check_val("m0_idle_outs", {busy_w[0], oe_w[0], miso_w[0]}, 3'b000);
        check_val("m0_no_underrun", n_unr[0] - u0, 0);
        check_val("m0_no_ferr", n_ferr[0] - f0, 0);

        // mode 3, 16-bit, two words in one frame
        u0 = n_unr[1];
        txd1 = 16'hCAFE; tx_valid[1] = 1'b1;
        tick(1);
        tx_valid[1] = 1'b0;
        frame_start(1);
        check_val("m3_txready", txr_w[1], 1'b1);
        xfer(1, 16, 1, 1, 1, 16'h1234, rd);
        check_val("m3_miso_w0", rd, 16'hCAFE);
        xfer(1, 16, 1, 1, 1, 16'hBEEF, rd);
        check_val("m3_miso_w1", rd, 16'h0000);
        frame_end(1);
        check_val("m3_nwords", log1.size(), 2);
        if (log1.size() >= 2) begin
            check_val("m3_rx_w0", log1[0], 16'h1234);
            check_val("m3_rx_w1", log1[1], 16'hBEEF);
        end
        check_val("m3_underrun", n_unr[1] - u0, 1);
        check_val("m3_no_overrun", n_ovr[1], 0);

        // overrun: two words with rx_ready low, holding register empty
        u0 = n_unr[0]; o0 = n_ovr[0];
        frame_start(0);
        xfer(0, 8, 0, 0, 1, 16'h0011, rd);
        check_val("ovr_miso_zero", rd, 16'h0000);
        xfer(0, 8, 0, 0, 1, 16'h0022, rd);
        frame_end(0);
        check_val("ovr_count", n_ovr[0] - o0, 1);
        check_val("ovr_rx_data", rxd0, 8'h22);
        check_val("ovr_rx_valid", rxv_w[0], 1'b1);
        check_val("ovr_underruns", n_unr[0] - u0, 2);

        // partial word then a clean frame
        rx_ready[0] = 1'b1;
        tick(2);
        rx_ready[0] = 1'b0;
        check_val("ferr_pre_valid", rxv_w[0], 1'b0);
        f0 = n_ferr[0]; v0 = n_rxv[0];
        frame_start(0);
        xfer(0, 5, 0, 0, 1, 16'h001F, rd);
        frame_end(0);
        check_val("ferr_pulse", n_ferr[0] - f0, 1);
        check_val("ferr_no_rxv", n_rxv[0] - v0, 0);
        frame_start(0);
        xfer(0, 8, 0, 0, 1, 16'h003C, rd);
        frame_end(0);
        check_val("ferr_next_data", rxd0, 8'h3C);
        check_val("ferr_next_valid", rxv_w[0], 1'b1);
        check_val("ferr_next_noerr", n_ferr[0] - f0, 1);

        // LSB first
        v0 = n_rxv[2];
        txd2 = 8'h01; tx_valid[2] = 1'b1;
        tick(1);
        tx_valid[2] = 1'b0;
        frame_start(2);
        xfer(2, 8, 0, 0, 0, 16'h0001, rd);
        check_val("lsb_miso", rd, 16'h0001);
        frame_end(2);
        check_val("lsb_rx_data", rxd2, 8'h01);
        check_val("lsb_rxv", n_rxv[2] - v0, 1);

        // reset in the middle of a word
        frame_start(2);
        xfer(2, 3, 0, 0, 0, 16'h00FF, rd);
        rst_n = 1'b0;
        tick(2);
        check_val("midrst_outs2", {miso_w[2], oe_w[2], rxv_w[2], txr_w[2], busy_w[2],
                                   ovr_w[2], unr_w[2], ferr_w[2]}, 8'b0001_0000);
        check_val("midrst_rxd2", rxd2, 8'h00);
        check_val("midrst_rxd0", rxd0, 8'h00);
        ce0[2] = 1'b1;
        sclk[2] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        f0 = n_ferr[2];
        txd2 = 8'h5A; tx_valid[2] = 1'b1;
        tick(1);
        tx_valid[2] = 1'b0;
        frame_start(2);
        xfer(2, 8, 0, 0, 0, 16'h0080, rd);
        check_val("post_rst_miso", rd, 16'h005A);
        frame_end(2);
        check_val("post_rst_rx", rxd2, 8'h80);
        check_val("post_rst_noerr", n_ferr[2] - f0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
